uxa_ps2_deserializer: RTL and testbench

Receive side of the UXA PS/2 port. Synchronizes and filters the raw PS/2 clock and data lines, then shifts in 11-bit device-to-host frames: start, 8 data LSB-first, odd parity, stop. Checks each frame and pushes valid bytes into the 16-byte UXA input FIFO with its two-step write protocol: data plus write strobe, then write-pointer increment. Reports parity, framing, timeout and overrun conditions to the register interface.

---
 rtl/uxa_ps2_deserializer.sv | 166 ++++++++++++++++
 tb/tb_uxa_ps2_deserializer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uxa_ps2_deserializer.sv
// PS/2 device-to-host receiver: synchronizes and filters the PS/2 lines, deframes
// 11-bit frames and writes checked bytes into the UXA input FIFO.
module uxa_ps2_deserializer #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic       sys_clk_i,
  input  logic       sys_reset_n_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       full_i,
  output logic [7:0] d_o,
  output logic       we_o,
  output logic       wp_inc_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       timeout_o,
  output logic       overrun_o,
  input  logic       overrun_clr_i
);

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WRITE, INC} state_e;

  logic       clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic       filt_q, filt_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic       fall_w;

  state_e     state_q;
  logic [2:0] bcnt_q;
  logic [7:0] shreg_q;
  logic       par_q;
  logic [15:0] tcnt_q;
  logic [7:0] d_q;
  logic       we_q, wpinc_q, perr_q, ferr_q, tout_q, ovr_q;

  always_ff @(posedge sys_clk_i or negedge sys_reset_n_i) begin
    if (!sys_reset_n_i) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
    end else begin
      clk_s1_q <= ps2_clk_i;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data_i;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // The falling edge is flagged in the cycle the filtered level flips, so the
  // FSM samples data in that same cycle.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall_w = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == 8'(FILTER_LEN - 1)) begin
        filt_d = ~filt_q;
        fall_w = filt_q;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_reset_n_i) begin
    if (!sys_reset_n_i) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tcnt_q  <= '0;
      d_q     <= '0;
      we_q    <= 1'b0;
      wpinc_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      tout_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      we_q    <= 1'b0;
      wpinc_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      tout_q  <= 1'b0;
      if (overrun_clr_i) ovr_q <= 1'b0;

      case (state_q)
        IDLE: begin
          tcnt_q <= '0;
          if (fall_w) begin
            if (!dat_s2_q) begin
              state_q <= DATA;
              bcnt_q  <= '0;
            end else begin
              ferr_q <= 1'b1;
            end
          end
        end

        DATA, PARITY, STOP: begin
          if (fall_w) begin
            tcnt_q <= '0;
            if (state_q == DATA) begin
              shreg_q[bcnt_q] <= dat_s2_q;
              bcnt_q          <= bcnt_q + 3'd1;
              if (bcnt_q == 3'd7) state_q <= PARITY;
            end else if (state_q == PARITY) begin
              par_q   <= dat_s2_q;
              state_q <= STOP;
            end else if (!dat_s2_q) begin
              ferr_q  <= 1'b1;
              state_q <= IDLE;
            end else if (!(^{shreg_q, par_q})) begin
              perr_q  <= 1'b1;
              state_q <= IDLE;
            end else if (full_i) begin
              ovr_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              d_q     <= shreg_q;
              we_q    <= 1'b1;
              state_q <= WRITE;
            end
          end else if (tcnt_q == 16'(TIMEOUT - 1)) begin
            tout_q  <= 1'b1;
            tcnt_q  <= '0;
            state_q <= IDLE;
          end else begin
            tcnt_q <= tcnt_q + 16'd1;
          end
        end

        WRITE: begin
          tcnt_q  <= '0;
          wpinc_q <= 1'b1;
          state_q <= INC;
        end

        INC: begin
          tcnt_q  <= '0;
          state_q <= IDLE;
        end

        default: begin
          tcnt_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign d_o          = d_q;
  assign we_o         = we_q;
  assign wp_inc_o     = wpinc_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign timeout_o    = tout_q;
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_uxa_ps2_deserializer.sv
// Directed bench for uxa_ps2_deserializer: PS/2 frames are driven bit by bit and
// FIFO strobes / error pulses are checked against a scoreboard of expected events.
module tb_uxa_ps2_deserializer;

  localparam int unsigned FL   = 8;
  localparam int unsigned TOUT = 300;
  localparam int HALF = 40;

  localparam int K_WR = 1, K_PE = 2, K_FE = 3, K_TO = 4;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       full = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] d_o;
  logic       we_o, wp_inc_o, parity_err_o, frame_err_o, timeout_o, overrun_o;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;
  ev_t sb[$];

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int tout_cyc = 0;
  bit tout_seen = 0;
  bit we_prev = 0;

  uxa_ps2_deserializer #(.FILTER_LEN(FL), .TIMEOUT(TOUT)) dut (
    .sys_clk_i     (sys_clk),
    .sys_reset_n_i (rst_n),
    .ps2_clk_i     (ps2_clk),
    .ps2_data_i    (ps2_data),
    .full_i        (full),
    .d_o           (d_o),
    .we_o          (we_o),
    .wp_inc_o      (wp_inc_o),
    .parity_err_o  (parity_err_o),
    .frame_err_o   (frame_err_o),
    .timeout_o     (timeout_o),
    .overrun_o     (overrun_o),
    .overrun_clr_i (clr)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic got(input int kind, input logic [7:0] data);
    ev_t e;
    tests_run++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL unexpected_event: observed kind %0d data %0h expected none", kind, data);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("event_kind", 16'(kind), 16'(e.kind));
      if (kind == K_WR) chk("write_data", {8'h00, data}, {8'h00, e.data});
    end
  endtask

  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (we_prev) chk("wp_inc_after_we", {15'd0, wp_inc_o}, 16'd1);
      else if (wp_inc_o) chk("wp_inc_without_we", {15'd0, wp_inc_o}, 16'd0);
      if (we_o) got(K_WR, d_o);
      if (parity_err_o) got(K_PE, 8'h00);
      if (frame_err_o) got(K_FE, 8'h00);
      if (timeout_o) begin
        got(K_TO, 8'h00);
        tout_seen = 1'b1;
        tout_cyc  = cyc;
      end
      we_prev = we_o;
    end else begin
      we_prev = 1'b0;
    end
  end

  function automatic logic [10:0] frame(input logic [7:0] d, input bit par_ok, input bit stop);
    logic par;
    par = par_ok ? ~(^d) : (^d);
    return {stop, par, d, 1'b0};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push(input int kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  // Device changes data while PS/2 clock is high; an optional short low glitch
  // precedes each real falling edge.
  task automatic send(input logic [10:0] b, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data = b[i];
      wait_cyc(HALF);
      if (glitch) begin
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(HALF);
      end
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      wait_cyc(HALF);
      ps2_clk  = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  initial begin
    bit seen;
    int delay;

    wait_cyc(3);
    #1;
    chk("rst_d", {8'h00, d_o}, 16'h0000);
    chk("rst_strobes", {10'd0, we_o, wp_inc_o, parity_err_o, frame_err_o, timeout_o, overrun_o}, 16'h0000);
    rst_n = 1'b1;
    wait_cyc(5);

    push(K_WR, 8'h1C);
    send(frame(8'h1C, 1, 1), 11, 0);
    chk("sb_empty_1C", 16'(sb.size()), 16'd0);

    push(K_PE, 8'h00);
    send(frame(8'hF0, 0, 1), 11, 0);
    chk("sb_empty_F0", 16'(sb.size()), 16'd0);

    push(K_FE, 8'h00);
    send(frame(8'hAA, 1, 0), 11, 0);
    chk("sb_empty_AA", 16'(sb.size()), 16'd0);

    push(K_WR, 8'h55);
    send(frame(8'h55, 1, 1), 11, 0);
    chk("sb_empty_55", 16'(sb.size()), 16'd0);

    push(K_FE, 8'h00);
    send(11'h7FF, 1, 0);
    chk("sb_empty_startbit1", 16'(sb.size()), 16'd0);

    tout_seen = 1'b0;
    push(K_TO, 8'h00);
    send(frame(8'h12, 1, 1), 5, 0);
    for (int j = 0; j < int'(TOUT) + 200 && !tout_seen; j++) wait_cyc(1);
    chk("timeout_seen", {15'd0, tout_seen}, 16'd1);
    delay = tout_cyc - fall_cyc;
    chk("timeout_delay_min", {15'd0, delay >= int'(TOUT + FL)}, 16'd1);
    chk("timeout_delay_max", {15'd0, delay <= int'(TOUT + FL + 4)}, 16'd1);
    push(K_WR, 8'h12);
    send(frame(8'h12, 1, 1), 11, 0);
    chk("sb_empty_12", 16'(sb.size()), 16'd0);

    full = 1'b1;
    send(frame(8'h1C, 1, 1), 11, 0);
    chk("overrun_set", {15'd0, overrun_o}, 16'd1);
    wait_cyc(50);
    chk("overrun_held", {15'd0, overrun_o}, 16'd1);
    full = 1'b0;
    clr  = 1'b1;
    wait_cyc(1);
    clr  = 1'b0;
    chk("overrun_cleared", {15'd0, overrun_o}, 16'd0);

    full = 1'b1;
    clr  = 1'b1;
    seen = 1'b0;
    fork
      send(frame(8'h1C, 1, 1), 11, 0);
      for (int j = 0; j < 3000 && !seen; j++) begin
        @(negedge sys_clk);
        if (overrun_o) begin
          seen = 1'b1;
          clr  = 1'b0;
        end
      end
    join
    clr = 1'b0;
    full = 1'b0;
    chk("overrun_set_beats_clr", {15'd0, seen}, 16'd1);
    wait_cyc(5);
    chk("overrun_after_set_clr", {15'd0, overrun_o}, 16'd1);

    push(K_WR, 8'h1C);
    send(frame(8'h1C, 1, 1), 11, 1);
    chk("sb_empty_glitch", 16'(sb.size()), 16'd0);

    send(frame(8'h1C, 1, 1), 4, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_d", {8'h00, d_o}, 16'h0000);
    chk("midrst_outs", {10'd0, we_o, wp_inc_o, parity_err_o, frame_err_o, timeout_o, overrun_o}, 16'h0000);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(int'(TOUT) + 100);
    chk("sb_empty_final", 16'(sb.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
